fir_seq_ctrl: RTL and testbench

Sequencer between the pin-level host interface and the FIR datapath instance. It synchronises a slow, pin-driven byte strobe and steers each byte either into the FIR coefficient load path or the sample path. It paces FIR samples so only one is in flight at a time, and captures the 11-bit FIR result into a held output register with a one-cycle valid pulse. It also tracks coefficient-load completeness and flags dropped bytes.

---
 rtl/fir_seq_pkg.sv | 18 +
 rtl/fir_seq_ctrl_if.sv | 30 +++
 rtl/fir_seq_ctrl_strobe_sync.sv | 17 +
 rtl/fir_seq_ctrl.sv | 107 ++++++++++
 tb/tb_fir_seq_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and default widths for the FIR sequencer slice.
package fir_seq_pkg;

  localparam int DW_DEF          = 8;
  localparam int OW_DEF          = 11;
  localparam int N_TAPS_DEF      = 4;
  localparam int FIR_LATENCY_DEF = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COEF,
    S_SAMPLE,
    S_WAIT,
    S_OUT
  } state_t;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Host pins, FIR datapath handshake and result signals of the sequencer.
interface fir_seq_ctrl_if #(
  parameter int DW = 8,
  parameter int OW = 11
);
  logic [DW-1:0] in_data;
  logic          in_strobe;
  logic          in_mode;
  logic [DW-1:0] fir_x_n;
  logic          fir_tvalid;
  logic          fir_set_coeffs;
  logic [OW-1:0] fir_y_n;
  logic [OW-1:0] y_data;
  logic          y_valid;
  logic          coef_ready;
  logic          busy;
  logic          overrun;

  modport master (
    output in_data, in_strobe, in_mode, fir_y_n,
    input  fir_x_n, fir_tvalid, fir_set_coeffs, y_data, y_valid,
           coef_ready, busy, overrun
  );

  modport slave (
    input  in_data, in_strobe, in_mode, fir_y_n,
    output fir_x_n, fir_tvalid, fir_set_coeffs, y_data, y_valid,
           coef_ready, busy, overrun
  );
endinterface

// File: rtl/fir_seq_ctrl_strobe_sync.sv
// Two-flop synchroniser for the pin-level strobe plus rising-edge detect.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic ev
);
  // [0],[1] are the synchroniser, [2] delays [1] for edge detection
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], strobe};
  end

  assign ev = sh[1] & ~sh[2];
endmodule

// File: rtl/fir_seq_ctrl.sv
// Byte sequencer: steers host bytes to FIR coefficient or sample path,
// paces one sample in flight and captures the FIR result.
module fir_seq_ctrl
  import fir_seq_pkg::*;
#(
  parameter int N_TAPS      = N_TAPS_DEF,
  parameter int FIR_LATENCY = FIR_LATENCY_DEF,
  parameter int DW          = DW_DEF,
  parameter int OW          = OW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_seq_ctrl_if.slave  bus
);
  localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  state_t             state, state_nxt;
  logic               ev;
  logic [IDX_W-1:0]   coef_idx;
  logic [CNT_W-1:0]   lat_cnt;
  logic               coef_ready;
  logic               overrun;
  logic [DW-1:0]      x_q;
  logic [OW-1:0]      y_q;
  logic               y_vld;

  logic idle, acc_coef, acc_smp, abort, drop, last_byte, cap;

  strobe_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (bus.in_strobe),
    .ev     (ev)
  );

  assign idle      = (state == S_IDLE);
  assign acc_coef  = idle && ev && bus.in_mode;
  assign abort     = idle && ev && !bus.in_mode && (coef_idx != '0);
  assign acc_smp   = idle && ev && !bus.in_mode && (coef_idx == '0) && coef_ready;
  assign drop      = ev && !acc_coef && !acc_smp;
  assign last_byte = (coef_idx == IDX_W'(N_TAPS - 1));
  assign cap       = (state == S_WAIT) && (lat_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (acc_coef)     state_nxt = S_COEF;
        else if (acc_smp) state_nxt = S_SAMPLE;
      end
      S_COEF:   state_nxt = S_IDLE;
      S_SAMPLE: state_nxt = S_WAIT;
      S_WAIT:   if (lat_cnt == '0) state_nxt = S_OUT;
      S_OUT:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // first byte of a load clears coef_ready (it is never the last unless N_TAPS==1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_idx   <= '0;
      coef_ready <= 1'b0;
      overrun    <= 1'b0;
      x_q        <= '0;
    end else begin
      if (acc_coef) begin
        x_q        <= bus.in_data;
        coef_idx   <= last_byte ? '0 : coef_idx + IDX_W'(1);
        coef_ready <= last_byte;
      end else if (abort) begin
        coef_idx   <= '0;
        coef_ready <= 1'b0;
      end
      if (acc_smp) x_q     <= bus.in_data;
      if (drop)    overrun <= 1'b1;
    end
  end

  // WAIT lasts FIR_LATENCY cycles; result is captured on its last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
      y_q     <= '0;
      y_vld   <= 1'b0;
    end else begin
      if (state == S_SAMPLE)                 lat_cnt <= CNT_W'(FIR_LATENCY - 1);
      else if (state == S_WAIT && !cap)      lat_cnt <= lat_cnt - CNT_W'(1);
      y_vld <= cap;
      if (cap) y_q <= bus.fir_y_n;
    end
  end

  assign bus.fir_x_n        = x_q;
  assign bus.fir_tvalid     = (state == S_SAMPLE);
  assign bus.fir_set_coeffs = (state == S_COEF);
  assign bus.y_data         = y_q;
  assign bus.y_valid        = y_vld;
  assign bus.coef_ready     = coef_ready;
  assign bus.busy           = !idle;
  assign bus.overrun        = overrun;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with hand-computed expectations.
module tb_fir_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.DW(8), .OW(11)) bus ();

  fir_seq_ctrl #(.N_TAPS(4), .FIR_LATENCY(2), .DW(8), .OW(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errs = 0, checks = 0;
  int tv_cnt = 0, sc_cnt = 0, yv_cnt = 0, both_cnt = 0, sc_run = 0;
  logic sc_prev = 1'b0;
  logic [7:0] sc_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.fir_tvalid) tv_cnt++;
    if (bus.fir_set_coeffs) begin
      sc_cnt++;
      sc_log.push_back(bus.fir_x_n);
      if (sc_prev) sc_run++;
    end
    if (bus.y_valid) yv_cnt++;
    if (bus.fir_tvalid && bus.fir_set_coeffs) both_cnt++;
    sc_prev = bus.fir_set_coeffs;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_x_n"},   32'(bus.fir_x_n), 0);
    chk({p, "_tvld"},  32'(bus.fir_tvalid), 0);
    chk({p, "_setc"},  32'(bus.fir_set_coeffs), 0);
    chk({p, "_ydat"},  32'(bus.y_data), 0);
    chk({p, "_yvld"},  32'(bus.y_valid), 0);
    chk({p, "_crdy"},  32'(bus.coef_ready), 0);
    chk({p, "_busy"},  32'(bus.busy), 0);
    chk({p, "_ovr"},   32'(bus.overrun), 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic send(input logic m, input logic [7:0] d);
    @(negedge clk);
    bus.in_mode = m; bus.in_data = d; bus.in_strobe = 1'b1;
    cyc(6);
    bus.in_strobe = 1'b0;
    cyc(8);
  endtask

  task automatic load4(input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, base + 8'(i));
      chk($sformatf("crdy_b%0d", i), 32'(bus.coef_ready), (i == 3) ? 1 : 0);
    end
  endtask

  task automatic wait_tv(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (bus.fir_tvalid) found = 1'b1;
    end
  endtask

  task automatic sample_timed(input logic [7:0] d, input logic [10:0] y);
    bit found;
    bus.fir_y_n = y;
    @(negedge clk);
    bus.in_mode = 1'b0; bus.in_data = d; bus.in_strobe = 1'b1;
    wait_tv(found);
    chk("tv_seen", 32'(found), 1);
    if (found) begin
      chk("tv_xn",    32'(bus.fir_x_n), 32'(d));
      chk("tv_busy",  32'(bus.busy), 1);
      cyc(1); chk("yv_e2", 32'(bus.y_valid), 0);
      cyc(1); chk("yv_e3", 32'(bus.y_valid), 0);
      cyc(1); chk("yv_e4", 32'(bus.y_valid), 1);
      chk("yd_e4",    32'(bus.y_data), 32'(y));
      chk("busy_e4",  32'(bus.busy), 1);
      cyc(1); chk("yv_e5", 32'(bus.y_valid), 0);
      chk("busy_e5",  32'(bus.busy), 0);
    end
    bus.in_strobe = 1'b0;
    cyc(6);
    chk("yd_held",  32'(bus.y_data), 32'(y));
  endtask

  initial begin
    int yv0, tv0;
    bit found;
    bus.in_data = '0; bus.in_strobe = 1'b0; bus.in_mode = 1'b0; bus.fir_y_n = '0;
    rst_n = 1'b0;
    cyc(3);
    chk_zero("rst");
    rst_n = 1'b1;
    cyc(2);

    // sample before any coefficients: dropped
    send(1'b0, 8'h10);
    chk("pre_tv",   32'(tv_cnt), 0);
    chk("pre_ovr",  32'(bus.overrun), 1);
    chk("pre_crdy", 32'(bus.coef_ready), 0);
    chk("pre_busy", 32'(bus.busy), 0);

    // full coefficient load
    load4(8'h01);
    chk("sc_cnt",  32'(sc_cnt), 4);
    chk("sc_size", 32'(sc_log.size()), 4);
    for (int i = 0; i < 4 && i < sc_log.size(); i++)
      chk($sformatf("sc_byte%0d", i), 32'(sc_log[i]), 32'(i + 1));
    chk("sc_xn", 32'(bus.fir_x_n), 32'h04);

    // sample through the FIR
    sample_timed(8'h20, 11'h155);
    chk("s1_tv", 32'(tv_cnt), 1);
    chk("s1_yv", 32'(yv_cnt), 1);

    // second strobe landing in WAIT is dropped
    do_reset;
    chk("r2_ovr",  32'(bus.overrun), 0);
    chk("r2_crdy", 32'(bus.coef_ready), 0);
    load4(8'h11);
    chk("l2_ovr", 32'(bus.overrun), 0);
    yv0 = yv_cnt; tv0 = tv_cnt;
    bus.fir_y_n = 11'h2AA;
    @(negedge clk);
    bus.in_mode = 1'b0; bus.in_data = 8'h30; bus.in_strobe = 1'b1;
    cyc(2); bus.in_strobe = 1'b0;
    cyc(1); bus.in_strobe = 1'b1;
    cyc(6); bus.in_strobe = 1'b0;
    cyc(10);
    chk("dw_ovr",  32'(bus.overrun), 1);
    chk("dw_yv",   32'(yv_cnt - yv0), 1);
    chk("dw_tv",   32'(tv_cnt - tv0), 1);
    chk("dw_yd",   32'(bus.y_data), 32'h2AA);
    chk("dw_xn",   32'(bus.fir_x_n), 32'h30);

    // partial load aborted by a sample byte
    do_reset;
    load4(8'h21);
    chk("ab_ovr0", 32'(bus.overrun), 0);
    send(1'b1, 8'h40);
    chk("ab_crdy1", 32'(bus.coef_ready), 0);
    send(1'b1, 8'h41);
    chk("ab_crdy2", 32'(bus.coef_ready), 0);
    tv0 = tv_cnt;
    send(1'b0, 8'h50);
    chk("ab_ovr",  32'(bus.overrun), 1);
    chk("ab_crdy", 32'(bus.coef_ready), 0);
    chk("ab_tv",   32'(tv_cnt - tv0), 0);
    load4(8'h61);
    sample_timed(8'h70, 11'h3C3);

    // reset asserted during WAIT
    bus.fir_y_n = 11'h0AB;
    @(negedge clk);
    bus.in_mode = 1'b0; bus.in_data = 8'h7F; bus.in_strobe = 1'b1;
    wait_tv(found);
    chk("rw_tv_seen", 32'(found), 1);
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk_zero("rw");
    bus.in_strobe = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    yv0 = yv_cnt;
    cyc(10);
    chk("rw_yv",   32'(yv_cnt - yv0), 0);
    chk("rw_crdy", 32'(bus.coef_ready), 0);
    chk("rw_busy", 32'(bus.busy), 0);

    chk("excl",   32'(both_cnt), 0);
    chk("sc_run", 32'(sc_run), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
